// File: rtl/fir_coef_ctrl_pkg.sv
// Shared constants and types for the FIR coefficient controller.
//   NB        sample/coefficient width (two's complement)
//   NT        filter order; the filter has NTAP = NT+1 taps
//   DRAIN_CYC cycles from the last filter VIN to the last filter VOUT
//   AW        coefficient address width (2**AW >= NTAP)
//   state_e   controller FSM states
package fir_coef_ctrl_pkg;

    localparam int unsigned NB        = 8;
    localparam int unsigned NT        = 10;
    localparam int unsigned NTAP      = NT + 1;
    localparam int unsigned DRAIN_CYC = 2;
    localparam int unsigned AW        = 4;
    localparam int unsigned BW        = NTAP * NB;

    // Drain counter holds DRAIN_CYC-1 down to 0; keep at least one bit.
    localparam int unsigned CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StSwap  = 2'd2
    } state_e;

endpackage

// File: rtl/fir_coef_ctrl_if.sv
// Bus bundle between the upstream/config master and the coefficient controller.
//   cfg_*      shadow-bank write port, commit request, busy and error status
//   s_*        upstream sample stream with ready/valid handshake
//   b          active coefficient bus to the filter (tap k at [(k+1)*NB-1:k*NB])
//   din, vin   sample and valid forwarded to the filter
//   filt_rst_n active-low delay-line clear to the filter
// Modport slave is the controller side; master is the driving environment.
interface fir_coef_ctrl_if;
    import fir_coef_ctrl_pkg::*;

    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [NB-1:0] cfg_data;
    logic          cfg_commit;
    logic          cfg_busy;
    logic          cfg_err;
    logic [NB-1:0] s_din;
    logic          s_vin;
    logic          s_ready;
    logic [BW-1:0] b;
    logic [NB-1:0] din;
    logic          vin;
    logic          filt_rst_n;

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, cfg_commit, s_din, s_vin,
        output cfg_busy, cfg_err, s_ready, b, din, vin, filt_rst_n
    );

    modport master (
        output cfg_we, cfg_addr, cfg_data, cfg_commit, s_din, s_vin,
        input  cfg_busy, cfg_err, s_ready, b, din, vin, filt_rst_n
    );

endinterface

// File: rtl/fir_coef_ctrl_bank.sv
// Coefficient storage: a word-writable shadow bank and the active B register.
//   clk, rst  clock and synchronous active-high reset (clears both banks)
//   we        write strobe; addr values above NT match no tap and are dropped
//   addr      tap index
//   data      coefficient value
//   load      copy the whole shadow bank into B on this edge
//   b         active coefficients, tap k at [(k+1)*NB-1:k*NB]
module fir_coef_ctrl_bank
    import fir_coef_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [NB-1:0] data,
    input  logic          load,
    output logic [BW-1:0] b
);

    logic [NTAP-1:0][NB-1:0] shadow_q, shadow_d;
    logic [NTAP-1:0][NB-1:0] b_q, b_d;

    always_comb begin
        shadow_d = shadow_q;
        for (int k = 0; k < NTAP; k++) begin
            if (we && (addr == AW'(k))) begin
                shadow_d[k] = data;
            end
        end
    end

    // Load copies the pre-edge shadow, so a write on the load edge lands in shadow only.
    always_comb begin
        b_d = b_q;
        if (load) begin
            b_d = shadow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            b_q      <= '0;
        end else begin
            shadow_q <= shadow_d;
            b_q      <= b_d;
        end
    end

    assign b = b_q;

endmodule

// File: rtl/fir_coef_ctrl.sv
// Coefficient swap sequencer in front of the FIR filter.
//   clk, rst  clock and synchronous active-high reset
//   bus       fir_coef_ctrl_if.slave: config port, sample stream in, filter-side outputs
// A commit stalls the sample stream, waits for the filter to drain, swaps the whole
// B bus in one edge while pulsing filt_rst_n low, then resumes samples, so no filter
// output is ever computed from a mix of old and new taps.
module fir_coef_ctrl
    import fir_coef_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    fir_coef_ctrl_if.slave bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               vin_q, vin_d;
    logic [NB-1:0]      din_q, din_d;
    logic               filt_rst_n_q, filt_rst_n_d;
    logic               cfg_err_q, cfg_err_d;
    logic               load;
    logic               s_ready;
    logic               accept;

    assign s_ready = (state_q == StRun);
    assign accept  = bus.s_vin & s_ready;

    // Commit FSM; commits while busy are dropped, not queued.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        filt_rst_n_d = filt_rst_n_q;
        load         = 1'b0;
        unique case (state_q)
            StRun: begin
                filt_rst_n_d = 1'b1;
                if (bus.cfg_commit) begin
                    state_d = StDrain;
                    cnt_d   = CNT_W'(DRAIN_CYC - 1);
                end
            end
            StDrain: begin
                if (cnt_q == '0) begin
                    state_d      = StSwap;
                    load         = 1'b1;
                    filt_rst_n_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StSwap: begin
                state_d      = StRun;
                filt_rst_n_d = 1'b1;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_comb begin
        vin_d     = accept;
        din_d     = accept ? bus.s_din : din_q;
        cfg_err_d = bus.cfg_we & (bus.cfg_addr > AW'(NT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            cnt_q        <= '0;
            vin_q        <= 1'b0;
            din_q        <= '0;
            filt_rst_n_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vin_q        <= vin_d;
            din_q        <= din_d;
            filt_rst_n_q <= filt_rst_n_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    fir_coef_ctrl_bank u_bank (
        .clk  (clk),
        .rst  (rst),
        .we   (bus.cfg_we),
        .addr (bus.cfg_addr),
        .data (bus.cfg_data),
        .load (load),
        .b    (bus.b)
    );

    assign bus.s_ready    = s_ready;
    assign bus.cfg_busy   = (state_q != StRun);
    assign bus.cfg_err    = cfg_err_q;
    assign bus.vin        = vin_q;
    assign bus.din        = din_q;
    assign bus.filt_rst_n = filt_rst_n_q;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl: reset, load/commit, streaming across a commit,
// busy commit, bad address and reset in the middle of a commit.
module tb_fir_coef_ctrl;
    import fir_coef_ctrl_pkg::*;

    localparam logic [87:0] B1 = 88'hFFFEFC0823322308FCFEFF;
    localparam logic [87:0] B2 = 88'hFFFEFC0823112308FCFEFF;
    localparam logic [87:0] B3 = 88'hFFFEFC0823112308FCFE55;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fir_coef_ctrl_if ifc ();

    fir_coef_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int addr, input logic [7:0] data);
        ifc.cfg_we   = 1'b1;
        ifc.cfg_addr = AW'(addr);
        ifc.cfg_data = data;
        tick();
        ifc.cfg_we   = 1'b0;
    endtask

    // Plain commit with no stream traffic; returns with the FSM back in RUN.
    task automatic commit();
        ifc.cfg_commit = 1'b1;
        tick();
        ifc.cfg_commit = 1'b0;
        tick();
        tick();
        tick();
    endtask

    logic [7:0] taps [11];
    logic [7:0] sv;
    logic [7:0] next_exp;
    int         delivered;
    int         busy_cnt;
    int         frst_low;

    initial begin
        taps = '{8'hFF, 8'hFE, 8'hFC, 8'h08, 8'h23, 8'h32, 8'h23, 8'h08, 8'hFC, 8'hFE, 8'hFF};
        ifc.cfg_we     = 1'b0;
        ifc.cfg_addr   = '0;
        ifc.cfg_data   = '0;
        ifc.cfg_commit = 1'b0;
        ifc.s_din      = '0;
        ifc.s_vin      = 1'b0;

        // T1 reset
        rst = 1'b1;
        tick();
        tick();
        tick();
        chkv("t1_b", ifc.b, 88'h0);
        chk1("t1_vin", ifc.vin, 1'b0);
        chk1("t1_frst", ifc.filt_rst_n, 1'b0);
        chk1("t1_err", ifc.cfg_err, 1'b0);
        chk1("t1_busy", ifc.cfg_busy, 1'b0);
        rst = 1'b0;
        tick();
        chk1("t1_frst_rel", ifc.filt_rst_n, 1'b1);
        chk1("t1_ready", ifc.s_ready, 1'b1);

        // T2 load and commit, one sample accepted in the commit cycle
        for (int k = 0; k < 11; k++) wr(k, taps[k]);
        chkv("t2_b_before", ifc.b, 88'h0);
        ifc.s_vin      = 1'b1;
        ifc.s_din      = 8'hA5;
        ifc.cfg_commit = 1'b1;
        tick();                                   // E0
        ifc.cfg_commit = 1'b0;
        ifc.s_din      = 8'h3C;
        chk1("t2_vin_e0", ifc.vin, 1'b1);
        chkv("t2_din_e0", 88'(ifc.din), 88'hA5);
        chk1("t2_ready_e0", ifc.s_ready, 1'b0);
        chk1("t2_busy_e0", ifc.cfg_busy, 1'b1);
        tick();                                   // E0+1
        chk1("t2_vin_e1", ifc.vin, 1'b0);
        chkv("t2_din_hold", 88'(ifc.din), 88'hA5);
        chkv("t2_b_e1", ifc.b, 88'h0);
        chk1("t2_frst_e1", ifc.filt_rst_n, 1'b1);
        tick();                                   // E0+2
        chkv("t2_b_e2", ifc.b, B1);
        chk1("t2_frst_e2", ifc.filt_rst_n, 1'b0);
        chk1("t2_ready_e2", ifc.s_ready, 1'b0);
        tick();                                   // E0+3
        chk1("t2_frst_e3", ifc.filt_rst_n, 1'b1);
        chk1("t2_ready_e3", ifc.s_ready, 1'b1);
        chk1("t2_busy_e3", ifc.cfg_busy, 1'b0);
        tick();
        chk1("t2_vin_resume", ifc.vin, 1'b1);
        chkv("t2_din_resume", 88'(ifc.din), 88'h3C);
        ifc.s_vin = 1'b0;
        tick();

        // T3 continuous stream across a commit: 12 offered cycles, 3 stalled
        sv        = 8'h10;
        next_exp  = 8'h10;
        delivered = 0;
        busy_cnt  = 0;
        frst_low  = 0;
        ifc.s_vin = 1'b1;
        for (int c = 0; c < 13; c++) begin
            logic acc;
            ifc.s_din      = sv;
            ifc.s_vin      = (c < 12);
            ifc.cfg_commit = (c == 3);
            acc = ifc.s_vin & ifc.s_ready;
            tick();
            if (acc) sv = sv + 8'd1;
            if (ifc.cfg_busy) busy_cnt++;
            if (!ifc.filt_rst_n) frst_low++;
            if (ifc.vin) begin
                chkv("t3_din_seq", 88'(ifc.din), 88'(next_exp));
                next_exp = next_exp + 8'd1;
                delivered++;
            end
        end
        ifc.s_vin      = 1'b0;
        ifc.cfg_commit = 1'b0;
        chkv("t3_delivered", 88'(delivered), 88'd9);
        chkv("t3_busy_cyc", 88'(busy_cnt), 88'd3);
        chkv("t3_frst_low", 88'(frst_low), 88'd1);
        chkv("t3_b", ifc.b, B1);

        // T4 write+commit same cycle, second commit while draining, write on swap edge
        ifc.cfg_we     = 1'b1;
        ifc.cfg_addr   = 4'd5;
        ifc.cfg_data   = 8'h11;
        ifc.cfg_commit = 1'b1;
        busy_cnt       = 0;
        tick();                                   // E0
        ifc.cfg_we = 1'b0;
        if (ifc.cfg_busy) busy_cnt++;
        tick();                                   // E0+1, commit still high: ignored
        ifc.cfg_commit = 1'b0;
        if (ifc.cfg_busy) busy_cnt++;
        ifc.cfg_we   = 1'b1;
        ifc.cfg_addr = 4'd0;
        ifc.cfg_data = 8'h55;
        tick();                                   // E0+2 swap edge
        ifc.cfg_we = 1'b0;
        if (ifc.cfg_busy) busy_cnt++;
        chkv("t4_b_swap", ifc.b, B2);
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ifc.cfg_busy) busy_cnt++;
        end
        chkv("t4_busy_cyc", 88'(busy_cnt), 88'd3);
        chkv("t4_b_after", ifc.b, B2);

        // T5 bad address
        wr(11, 8'h7F);
        chk1("t5_err_pulse", ifc.cfg_err, 1'b1);
        chkv("t5_b_unch", ifc.b, B2);
        tick();
        chk1("t5_err_clear", ifc.cfg_err, 1'b0);
        commit();
        chkv("t5_b_shadow", ifc.b, B3);

        // T6 reset in the first drain cycle
        wr(3, 8'h77);
        ifc.cfg_commit = 1'b1;
        tick();                                   // E0, now draining
        ifc.cfg_commit = 1'b0;
        chk1("t6_busy_pre", ifc.cfg_busy, 1'b1);
        rst = 1'b1;
        tick();
        chk1("t6_busy_rst", ifc.cfg_busy, 1'b0);
        chkv("t6_b_rst", ifc.b, 88'h0);
        chk1("t6_frst_rst", ifc.filt_rst_n, 1'b0);
        rst = 1'b0;
        frst_low = 0;
        busy_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (!ifc.filt_rst_n) frst_low++;
            if (ifc.cfg_busy) busy_cnt++;
        end
        chkv("t6_no_glitch", 88'(frst_low), 88'd0);
        chkv("t6_no_busy", 88'(busy_cnt), 88'd0);
        chkv("t6_b_idle", ifc.b, 88'h0);
        commit();
        chkv("t6_shadow_lost", ifc.b, 88'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
